// File: rtl/ts_pkg.sv
// ts_pkg: shared types and constants for the sound-chip bus scheduler.
//   state_t     - scheduler FSM states
//   entry_t     - queued CPU write {a, d}; a=1 address/control port, a=0 data port
//   CTRL_PREFIX - d[7:3] pattern marking a chip-select/FM-enable control byte
//   FM_REG_MIN  - lowest register address whose writes need FM settle time
package ts_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [4:0] CTRL_PREFIX = 5'b11111;
    localparam logic [7:0] FM_REG_MIN  = 8'h10;

    typedef struct packed {
        logic       a;
        logic [7:0] d;
    } entry_t;

endpackage

// File: rtl/ts_fifo.sv
// ts_fifo: synchronous write FIFO of 9-bit entries.
//   CLK, RESET   - clock, asynchronous active-high reset
//   push, wdata  - write strobe and data (ignored when full)
//   pop, rdata   - read strobe (ignored when empty); rdata shows the head entry
//   full, empty  - occupancy flags
//   count        - current number of entries (0..DEPTH)
module ts_fifo #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          push,
    input  logic [8:0]    wdata,
    input  logic          pop,
    output logic [8:0]    rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers are exactly AW bits wide, so DEPTH being a power of two
    // makes the increment wrap modulo DEPTH for free.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ts_bus_sched.sv
// ts_bus_sched: queues CPU port writes and replays them onto the sound-chip
// bus, holding off after FM register writes so the chip has time to settle.
//   CLK, RESET      - clock, asynchronous active-high reset
//   CE_CPU          - CPU clock enable; a bus cycle ends on the next CE_CPU
//   CE_YM           - YM master clock enable x2; paces the FM hold-off
//   cpu_wr, cpu_rd  - one-CLK write strobe / read request
//   cpu_a, cpu_di   - port select (1 = FFFD address, 0 = BFFD data), data
//   cpu_wait        - CPU stall request
//   BDIR, BC, DO    - bus direction, bus control and data to the sound block
module ts_bus_sched
    import ts_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADDR_WAIT = 24,
    parameter int unsigned DATA_WAIT = 166
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CE_CPU,
    input  logic       CE_YM,
    input  logic       cpu_wr,
    input  logic       cpu_rd,
    input  logic       cpu_a,
    input  logic [7:0] cpu_di,
    output logic       cpu_wait,
    output logic       BDIR,
    output logic       BC,
    output logic [7:0] DO
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    state_t        state;
    entry_t        head;
    entry_t        cur;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          pop;
    logic [15:0]   cnt;
    logic          ovf;
    logic          sel;
    logic          fm_ena;
    logic [7:0]    addr [2];
    logic          is_ctrl;
    logic          fm_timed;

    ts_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (cpu_wr),
        .wdata ({cpu_a, cpu_di}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign pop = (state == ST_IDLE) && !fifo_empty;

    assign cpu_wait = (fifo_count >= CW'(DEPTH - 1)) ||
                      (cpu_rd && (!fifo_empty || state != ST_IDLE));

    // Control bytes never reach the FM register file, so they are excluded
    // from address timing; data timing uses the chip's currently latched
    // register address, evaluated before this write updates the shadow.
    assign is_ctrl  = cur.a && (cur.d[7:3] == CTRL_PREFIX);
    assign fm_timed = fm_ena && (cur.a ? (!is_ctrl && (cur.d >= FM_REG_MIN))
                                       : (addr[sel] >= FM_REG_MIN));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= ST_IDLE;
            cur     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            sel     <= 1'b1;
            fm_ena  <= 1'b0;
            addr[0] <= '0;
            addr[1] <= '0;
            BDIR    <= 1'b0;
            BC      <= 1'b0;
            DO      <= '0;
        end else begin
            if (cpu_wr && fifo_full)
                ovf <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        cur   <= head;
                        state <= ST_DRIVE;
                        BDIR  <= 1'b1;
                        BC    <= head.a;
                        DO    <= head.d;
                    end
                end
                ST_DRIVE: begin
                    if (CE_CPU) begin
                        BDIR <= 1'b0;
                        BC   <= 1'b0;
                        DO   <= '0;
                        if (is_ctrl) begin
                            sel    <= cur.d[0];
                            fm_ena <= ~cur.d[2];
                        end else if (cur.a) begin
                            addr[sel] <= cur.d;
                        end
                        if (fm_timed) begin
                            state <= ST_HOLD;
                            cnt   <= cur.a ? 16'(ADDR_WAIT) : 16'(DATA_WAIT);
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (CE_YM) begin
                        cnt <= cnt - 1'b1;
                        if (cnt <= 16'd1)
                            state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    BDIR  <= 1'b0;
                    BC    <= 1'b0;
                    DO    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ts_bus_sched.sv
// tb_ts_bus_sched: self-checking bench for ts_bus_sched. Expected bus cycles
// {BC, DO, hold length in CE_YM ticks} are queued as writes are issued and
// checked by a bus monitor as the DUT replays them.
module tb_ts_bus_sched;
    import ts_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 24;
    localparam int unsigned DW    = 166;

    logic       CLK    = 1'b0;
    logic       RESET  = 1'b1;
    logic       CE_CPU = 1'b0;
    logic       CE_YM  = 1'b0;
    logic       cpu_wr = 1'b0;
    logic       cpu_rd = 1'b0;
    logic       cpu_a  = 1'b0;
    logic [7:0] cpu_di = 8'h00;
    logic       cpu_wait;
    logic       BDIR;
    logic       BC;
    logic [7:0] DO;

    ts_bus_sched #(
        .DEPTH     (DEPTH),
        .ADDR_WAIT (AW),
        .DATA_WAIT (DW)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .CE_CPU   (CE_CPU),
        .CE_YM    (CE_YM),
        .cpu_wr   (cpu_wr),
        .cpu_rd   (cpu_rd),
        .cpu_a    (cpu_a),
        .cpu_di   (cpu_di),
        .cpu_wait (cpu_wait),
        .BDIR     (BDIR),
        .BC       (BC),
        .DO       (DO)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        a;
        logic [7:0]  d;
        int unsigned hold;
    } xfer_t;

    xfer_t       sb[$];
    xfer_t       vecs[18];
    int unsigned n_cmp     = 0;
    int unsigned n_bad     = 0;
    int unsigned mon_phase = 0;
    int unsigned ph        = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Clock enables: CE_YM every 2nd CLK, CE_CPU every 3rd CLK.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            ph++;
            CE_YM  = (ph % 2 == 0);
            CE_CPU = (ph % 3 == 0);
        end
    end

    // Bus monitor: matches each DRIVE against the scoreboard, checks its
    // length against CE_CPU and counts CE_YM ticks spent in HOLD.
    initial begin
        xfer_t       cur;
        logic        prev_bdir;
        logic        exit_due;
        int unsigned hold_ce;
        prev_bdir = 1'b0;
        exit_due  = 1'b0;
        hold_ce   = 0;
        cur       = '{1'b0, 8'h00, 0};
        forever begin
            @(negedge CLK);
            if (RESET) begin
                mon_phase = 0;
                prev_bdir = 1'b0;
            end else begin
                if (mon_phase == 1) begin
                    check("drive_len", BDIR, !exit_due);
                    if (!BDIR) begin
                        hold_ce = 0;
                        if (dut.state == ST_HOLD) begin
                            mon_phase = 2;
                        end else begin
                            check("hold_ce", hold_ce, cur.hold);
                            mon_phase = 0;
                        end
                    end else begin
                        exit_due = CE_CPU;
                    end
                end
                if (mon_phase == 2) begin
                    if (dut.state == ST_HOLD) begin
                        if (CE_YM)
                            hold_ce++;
                    end else begin
                        check("hold_ce", hold_ce, cur.hold);
                        mon_phase = 0;
                    end
                end
                if (!BDIR)
                    check("idle_bus", {BC, DO}, 0);
                if (mon_phase == 0 && BDIR && !prev_bdir) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_drive: actual BC=%0b DO=%0h required none at %0t",
                                 BC, DO, $time);
                    end else begin
                        cur = sb.pop_front();
                        check("BC", BC, cur.a);
                        check("DO", DO, cur.d);
                        exit_due  = CE_CPU;
                        mon_phase = 1;
                    end
                end
                prev_bdir = BDIR;
            end
        end
    end

    // Waits for a free slot (cpu_wait low), then issues one write.
    task automatic push_vec(input xfer_t v);
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge CLK);
            #1;
            if (!cpu_wait) begin
                ok = 1'b1;
                break;
            end
        end
        check("push_ready", ok, 1);
        cpu_a  = v.a;
        cpu_di = v.d;
        cpu_wr = 1'b1;
        sb.push_back(v);
        @(posedge CLK);
        #1 cpu_wr = 1'b0;
    endtask

    task automatic cpu_write(input logic a, input logic [7:0] d, input int unsigned hold);
        xfer_t v;
        v = '{a, d, hold};
        push_vec(v);
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge CLK);
            if (sb.size() == 0 && mon_phase == 0 && dut.state == ST_IDLE && dut.fifo_empty) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_idle"}, ok, 1);
    endtask

    task automatic wait_hold(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (dut.state == ST_HOLD) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_hold"}, ok, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // {a, d, expected CE_YM hold}; shadow starts at sel=1, fm_ena=0,
        // addr[1]=07 after the opening hand-written sequence.
        vecs = '{
            '{1'b1, 8'hFA, 0},   // sel=0, fm_ena=1
            '{1'b1, 8'h28, AW},  // addr[0]=28
            '{1'b0, 8'hF0, DW},
            '{1'b1, 8'h05, 0},   // below FM range
            '{1'b0, 8'h11, 0},
            '{1'b1, 8'hFF, 0},   // sel=1, fm_ena=0
            '{1'b1, 8'h28, 0},   // addr[1]=28, FM disabled
            '{1'b0, 8'hAA, 0},
            '{1'b1, 8'hF9, 0},   // sel=1, fm_ena=1
            '{1'b0, 8'h55, DW},  // chip 1 addr 28
            '{1'b1, 8'hF8, 0},   // sel=0, fm_ena=1
            '{1'b0, 8'h66, 0},   // chip 0 addr still 05
            '{1'b1, 8'h10, AW},  // threshold
            '{1'b0, 8'h01, DW},
            '{1'b1, 8'h0F, 0},   // just below threshold
            '{1'b0, 8'h02, 0},
            '{1'b1, 8'hF7, AW},  // highest non-control address
            '{1'b0, 8'h03, DW}
        };

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_bus", {BDIR, BC, DO}, 0);
        check("rst_wait", cpu_wait, 0);
        check("rst_ovf", dut.ovf, 0);
        check("rst_sel", dut.sel, 1);
        check("rst_fm_ena", dut.fm_ena, 0);
        check("rst_state_idle", dut.state == ST_IDLE, 1);
        check("rst_fifo_empty", dut.fifo_empty, 1);
        check("rst_addr", {dut.addr[1], dut.addr[0]}, 0);
        check("rst_cnt", dut.cnt, 0);
        @(posedge CLK);
        #1 RESET = 1'b0;

        // Address then data write with FM off; checks the 2-CLK latency
        cpu_write(1'b1, 8'h07, 0);
        @(negedge CLK);
        check("latency_1clk", BDIR, 0);
        @(negedge CLK);
        check("latency_2clk", BDIR, 1);
        cpu_write(1'b0, 8'h38, 0);
        wait_idle("basic");
        check("basic_empty", dut.fifo_empty, 1);

        for (int i = 0; i < 18; i++)
            push_vec(vecs[i]);
        wait_idle("table");

        // Six back-to-back writes during a HOLD: 5th and 6th are dropped
        cpu_write(1'b1, 8'h28, AW);
        wait_hold("ovf");
        @(posedge CLK);
        #1;
        for (int i = 0; i < 6; i++) begin
            cpu_a  = 1'b1;
            cpu_di = 8'(i + 1);
            cpu_wr = 1'b1;
            if (i < 4)
                sb.push_back('{1'b1, 8'(i + 1), 0});
            @(posedge CLK);
            #1;
            check("ovf_wait", cpu_wait, (i >= 2));
            check("ovf_flag", dut.ovf, (i >= 4));
        end
        cpu_wr = 1'b0;
        wait_idle("ovf");
        check("ovf_sticky", dut.ovf, 1);

        // cpu_rd with two writes pending behind a HOLD
        cpu_write(1'b1, 8'h10, AW);
        wait_hold("rd");
        cpu_write(1'b1, 8'h01, 0);
        cpu_write(1'b1, 8'h02, 0);
        cpu_rd = 1'b1;
        @(negedge CLK);
        check("rd_wait_start", cpu_wait, 1);
        begin
            bit dropped = 1'b0;
            for (int i = 0; i < 2000; i++) begin
                @(negedge CLK);
                if (!cpu_wait) begin
                    dropped = 1'b1;
                    break;
                end
            end
            check("rd_wait_release", dropped, 1);
        end
        check("rd_release_idle", dut.state == ST_IDLE, 1);
        check("rd_release_empty", dut.fifo_empty, 1);
        check("rd_release_sb", sb.size(), 0);
        cpu_rd = 1'b0;
        wait_idle("rd");

        // Reset pulse in the middle of a HOLD
        cpu_write(1'b1, 8'h28, AW);
        wait_hold("mid_rst");
        repeat (5) @(posedge CLK);
        #2 RESET = 1'b1;
        @(negedge CLK);
        check("mid_rst_idle", dut.state == ST_IDLE, 1);
        check("mid_rst_bdir", BDIR, 0);
        check("mid_rst_sel", dut.sel, 1);
        @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check("post_rst_bus", {BDIR, BC, DO}, 0);
        cpu_write(1'b1, 8'h33, 0);
        cpu_write(1'b0, 8'h44, 0);
        wait_idle("post_rst");

        check("final_sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
